// File: rtl/fifo_1ton_sc.sv
// Single-clock packing FIFO: gathers NSIZE elements of DSIZE bits into one output
// word, with flush-to-close partial words, first-word-fall-through reads and error pulses.
module fifo_1ton_sc #(
  parameter int                 DSIZE     = 8,
  parameter int                 NSIZE     = 4,
  parameter int                 DEPTH     = 16,
  parameter int                 ALMOST    = 2,
  parameter logic [DSIZE-1:0]   DEF_VALUE = '0,
  parameter string              MSB_FIRST = "ON",
  localparam int                AW        = $clog2(DEPTH),
  localparam int                CW        = AW + 1,
  localparam int                SF        = $clog2(NSIZE),
  localparam int                WW        = DSIZE * NSIZE
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DSIZE-1:0]  wr_data,
  input  logic              wr_flush,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [CW+SF-1:0]  wr_count,
  output logic              wr_err,
  input  logic              rd_en,
  output logic [WW-1:0]     rd_data,
  output logic              rd_vld,
  output logic              rd_empty,
  output logic              rd_last,
  output logic              rd_almost_empty,
  output logic [CW-1:0]     rd_count,
  output logic              rd_err
);

  localparam int             LW       = (SF > 0) ? SF : 1;
  localparam bit             MSB_ON   = (MSB_FIRST == "ON");
  localparam logic [WW-1:0]  DEF_WORD = {NSIZE{DEF_VALUE}};

  logic [WW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] last_mem;
  logic [WW-1:0]   asm_q, asm_next, hold_q;
  logic            hold_last_q;
  logic [LW-1:0]   lane_q;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            wr_err_q, rd_err_q;

  logic full, vld, wr_acc, lane_end, flush_ok, commit, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign vld      = (count_q != '0);
  assign wr_acc   = wr_en && !full;
  assign lane_end = (lane_q == LW'(NSIZE - 1));
  assign flush_ok = wr_flush && !full && ((lane_q != '0) || wr_acc);
  assign commit   = (wr_acc && lane_end) || flush_ok;
  assign pop      = rd_en && vld;

  // Unfilled lanes of asm_q already hold DEF_VALUE, so a flush commits asm_next as is.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < NSIZE; i++) begin
      if (wr_acc && (lane_q == LW'(i))) begin
        if (MSB_ON) asm_next[(NSIZE-1-i)*DSIZE +: DSIZE] = wr_data;
        else        asm_next[i*DSIZE +: DSIZE]           = wr_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (commit) begin
      mem[wptr_q]      <= asm_next;
      last_mem[wptr_q] <= flush_ok;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= DEF_WORD;
      lane_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      hold_q      <= DEF_WORD;
      hold_last_q <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      if (commit) begin
        asm_q  <= DEF_WORD;
        lane_q <= '0;
        wptr_q <= wptr_q + AW'(1);
      end else if (wr_acc) begin
        asm_q  <= asm_next;
        lane_q <= lane_q + LW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (commit && !pop)      count_q <= count_q + CW'(1);
      else if (!commit && pop) count_q <= count_q - CW'(1);
      // Remember the word on show so the outputs hold once the FIFO drains.
      if (vld) begin
        hold_q      <= mem[rptr_q];
        hold_last_q <= last_mem[rptr_q];
      end
      wr_err_q <= (wr_en || wr_flush) && full;
      rd_err_q <= rd_en && !vld;
    end
  end

  assign rd_data         = vld ? mem[rptr_q] : hold_q;
  assign rd_last         = vld ? last_mem[rptr_q] : hold_last_q;
  assign rd_vld          = vld;
  assign rd_empty        = !vld;
  assign rd_count        = count_q;
  assign rd_almost_empty = (count_q <= CW'(ALMOST));
  assign rd_err          = rd_err_q;
  assign wr_full         = full;
  assign wr_almost_full  = (count_q >= CW'(DEPTH - ALMOST));
  assign wr_count        = (CW+SF)'(count_q) * (CW+SF)'(NSIZE) + (CW+SF)'(lane_q);
  assign wr_err          = wr_err_q;

endmodule

// File: tb/tb_fifo_1ton_sc.sv
// Directed bench for fifo_1ton_sc with DSIZE=8, NSIZE=4, DEPTH=4, ALMOST=1, MSB lane first.
module tb_fifo_1ton_sc;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_flush = 1'b0;
  logic        wr_full, wr_almost_full, wr_err;
  logic [4:0]  wr_count;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_vld, rd_empty, rd_last, rd_almost_empty, rd_err;
  logic [2:0]  rd_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fifo_1ton_sc #(.DSIZE(8), .NSIZE(4), .DEPTH(4), .ALMOST(1),
                 .DEF_VALUE(8'h00), .MSB_FIRST("ON")) dut (
    .clock(clock), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_flush(wr_flush),
    .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .wr_count(wr_count), .wr_err(wr_err),
    .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld), .rd_empty(rd_empty),
    .rd_last(rd_last), .rd_almost_empty(rd_almost_empty),
    .rd_count(rd_count), .rd_err(rd_err)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic fl);
    wr_en = 1'b1; wr_data = d; wr_flush = fl;
    tick();
    wr_en = 1'b0; wr_flush = 1'b0;
  endtask

  task automatic flush_only();
    wr_flush = 1'b1;
    tick();
    wr_flush = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  logic [31:0] word;
  logic [31:0] drain [3];
  int npop;

  initial begin
    // reset values
    #12;
    check("rst_vld", rd_vld, 0);
    check("rst_empty", rd_empty, 1);
    check("rst_last", rd_last, 0);
    check("rst_full", wr_full, 0);
    check("rst_afull", wr_almost_full, 0);
    check("rst_aempty", rd_almost_empty, 1);
    check("rst_werr", wr_err, 0);
    check("rst_rerr", rd_err, 0);
    check("rst_data", rd_data, 32'h0);
    check("rst_wcnt", wr_count, 0);
    check("rst_rcnt", rd_count, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    tick();

    // full word packing
    put(8'h11, 0); put(8'h22, 0);
    check("part_wcnt", wr_count, 2);
    check("part_vld", rd_vld, 0);
    put(8'h33, 0); put(8'h44, 0);
    check("w1_vld", rd_vld, 1);
    check("w1_data", rd_data, 32'h11223344);
    check("w1_last", rd_last, 0);
    check("w1_rcnt", rd_count, 1);
    check("w1_wcnt", wr_count, 4);
    check("w1_aempty", rd_almost_empty, 1);
    pop_one();
    check("pop1_vld", rd_vld, 0);
    check("pop1_empty", rd_empty, 1);
    check("pop1_hold", rd_data, 32'h11223344);
    check("pop1_rcnt", rd_count, 0);

    // flush of partial words
    put(8'hAA, 0); put(8'hBB, 0);
    flush_only();
    check("fl1_data", rd_data, 32'hAABB0000);
    check("fl1_last", rd_last, 1);
    check("fl1_wcnt", wr_count, 4);
    pop_one();
    check("fl1_hold_last", rd_last, 1);
    put(8'hCC, 1);
    check("fl2_data", rd_data, 32'hCC000000);
    check("fl2_last", rd_last, 1);
    pop_one();
    flush_only();
    check("fl0_rcnt", rd_count, 0);
    check("fl0_wcnt", wr_count, 0);
    check("fl0_werr", wr_err, 0);
    // flush together with the fourth element closes exactly one word
    put(8'h61, 0); put(8'h62, 0); put(8'h63, 0); put(8'h64, 1);
    check("fl3_rcnt", rd_count, 1);
    check("fl3_data", rd_data, 32'h61626364);
    check("fl3_last", rd_last, 1);
    check("fl3_wcnt", wr_count, 4);
    pop_one();

    // fill to full, overflow, flush while full
    for (int i = 1; i <= 16; i++) put(8'(i), 0);
    check("full_full", wr_full, 1);
    check("full_afull", wr_almost_full, 1);
    check("full_aempty", rd_almost_empty, 0);
    check("full_rcnt", rd_count, 4);
    check("full_wcnt", wr_count, 16);
    put(8'h99, 0);
    check("ovf_werr", wr_err, 1);
    check("ovf_wcnt", wr_count, 16);
    tick();
    check("ovf_werr_clr", wr_err, 0);
    flush_only();
    check("ovfl_werr", wr_err, 1);
    check("ovfl_rcnt", rd_count, 4);
    check("ovfl_head", rd_data, 32'h01020304);
    check("ovfl_last", rd_last, 0);
    pop_one();
    check("p_full", wr_full, 0);
    check("p_afull", wr_almost_full, 1);
    check("p_head", rd_data, 32'h05060708);
    put(8'h21, 0); put(8'h22, 0); put(8'h23, 0);
    check("p_wcnt", wr_count, 15);
    // commit and pop on the same edge
    wr_en = 1'b1; wr_data = 8'h24; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("cp_rcnt", rd_count, 3);
    check("cp_wcnt", wr_count, 12);
    drain[0] = 32'h090A0B0C; drain[1] = 32'h0D0E0F10; drain[2] = 32'h21222324;
    for (int i = 0; i < 3; i++) begin
      check("drain", rd_data, drain[i]);
      pop_one();
    end
    check("dr_empty", rd_empty, 1);
    check("dr_hold", rd_data, 32'h21222324);

    // pop from empty
    pop_one();
    check("uf_rerr", rd_err, 1);
    check("uf_rcnt", rd_count, 0);
    check("uf_wcnt", wr_count, 0);
    check("uf_hold", rd_data, 32'h21222324);
    tick();
    check("uf_rerr_clr", rd_err, 0);

    // streaming through three pointer wraps with rd_en held high (scoreboard)
    rd_en = 1'b1;
    npop = 0;
    word = '0;
    for (int k = 0; k < 48; k++) begin
      wr_en = 1'b1;
      wr_data = 8'(k * 5 + 3);
      word = {word[23:0], wr_data};
      tick();
      if ((k % 4) == 3) exp_q.push_back(word);
      if (exp_q.size() > 0) begin
        check("st_vld", rd_vld, 1);
        check("st_data", rd_data, exp_q.pop_front());
        npop++;
      end else begin
        check("st_idle", rd_vld, 0);
      end
    end
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    check("st_npop", npop, 12);
    check("st_rcnt", rd_count, 0);
    check("st_wcnt", wr_count, 0);
    check("st_rerr", rd_err, 0);

    // reset in the middle of a packet
    put(8'h01, 0); put(8'h02, 0);
    check("mr_wcnt_pre", wr_count, 2);
    rst_n = 1'b0;
    #2;
    check("mr_wcnt", wr_count, 0);
    check("mr_data", rd_data, 32'h0);
    check("mr_vld", rd_vld, 0);
    tick();
    rst_n = 1'b1;
    tick();
    put(8'h5A, 0); put(8'h6B, 0); put(8'h7C, 0); put(8'h8D, 0);
    check("mr_word", rd_data, 32'h5A6B7C8D);
    check("mr_last", rd_last, 0);
    check("mr_rcnt", rd_count, 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
